// File: rtl/dtc_class_inverter_if.sv
// ---------------------------------------------------------------------------
// dtc_class_inverter_if
// Bundles the request/response handshakes and the classifier drive/return
// pair of the decision-tree class inverter.
//
// Signals:
//   req_valid / req_ready / req_class    : request handshake, target class
//   resp_valid / resp_ready              : response handshake
//   resp_found / resp_vec                : search result (lowest match)
//   resp_count                           : match count (only with DTC_INV_COUNT_EN)
//   cls_inp                              : candidate driven to the classifier
//   cls_outp                             : classifier class for cls_inp
//
// Modports:
//   slave  : the inverter itself
//   master : the requester / classifier side
//
// Optional build macro: DTC_INV_COUNT_EN adds resp_count.
// ---------------------------------------------------------------------------
interface dtc_class_inverter_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [OUT_W-1:0] req_class;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_found;
    logic [IN_W-1:0]  resp_vec;
`ifdef DTC_INV_COUNT_EN
    logic [IN_W:0]    resp_count;
`endif
    logic [IN_W-1:0]  cls_inp;
    logic [OUT_W-1:0] cls_outp;

`ifdef DTC_INV_COUNT_EN
    modport slave (
        input  req_valid, req_class, resp_ready, cls_outp,
        output req_ready, resp_valid, resp_found, resp_vec, resp_count, cls_inp
    );
    modport master (
        output req_valid, req_class, resp_ready, cls_outp,
        input  req_ready, resp_valid, resp_found, resp_vec, resp_count, cls_inp
    );
`else
    modport slave (
        input  req_valid, req_class, resp_ready, cls_outp,
        output req_ready, resp_valid, resp_found, resp_vec, cls_inp
    );
    modport master (
        output req_valid, req_class, resp_ready, cls_outp,
        input  req_ready, resp_valid, resp_found, resp_vec, cls_inp
    );
`endif
endinterface

// File: rtl/dtc_class_inverter.sv
// ---------------------------------------------------------------------------
// dtc_class_inverter
// Sequential inverse of a combinational decision-tree classifier. Given a
// requested class code it sweeps the classifier input space one candidate
// per cycle (driving an external classifier through cls_inp / cls_outp) and
// returns the lowest input vector mapped to that class.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : dtc_class_inverter_if.slave
//          req_valid/req_ready/req_class   request handshake
//          resp_valid/resp_ready           response handshake
//          resp_found/resp_vec             result (vec = 0 when not found)
//          resp_count                      match count (DTC_INV_COUNT_EN)
//          cls_inp/cls_outp                classifier drive / result
//
// Optional build macro: DTC_INV_COUNT_EN
//   Defined   : always sweeps the full space, counts every match in
//               resp_count, resp_vec still holds the lowest match.
//   Undefined : search stops at the first match.
// ---------------------------------------------------------------------------
module dtc_class_inverter #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    dtc_class_inverter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESP   = 2'd2
    } state_t;

    // One extra bit so the terminal compare never aliases a wrapped value.
    localparam logic [IN_W:0] CAND_LAST = {1'b0, {IN_W{1'b1}}};

    state_t           state;
    state_t           state_next;
    logic [IN_W:0]    cand;
    logic [OUT_W-1:0] target;
    logic             found;
    logic [IN_W-1:0]  vec;
`ifdef DTC_INV_COUNT_EN
    logic [IN_W:0]    count;
`endif

    logic match;
    logic last;

    // The classifier result only matters while sweeping.
    assign match = (state == SEARCH) && (bus.cls_outp == target);
    assign last  = (cand == CAND_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next = SEARCH;
                end
            end
            SEARCH: begin
`ifdef DTC_INV_COUNT_EN
                if (last) begin
                    state_next = RESP;
                end
`else
                if (match || last) begin
                    state_next = RESP;
                end
`endif
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Candidate counter, target and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand   <= '0;
            target <= '0;
            found  <= 1'b0;
            vec    <= '0;
`ifdef DTC_INV_COUNT_EN
            count  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        target <= bus.req_class;
                        cand   <= '0;
                        // Clearing here makes the not-found result fall out
                        // naturally: nothing is written during a failed sweep.
                        found  <= 1'b0;
                        vec    <= '0;
`ifdef DTC_INV_COUNT_EN
                        count  <= '0;
`endif
                    end
                end
                SEARCH: begin
`ifdef DTC_INV_COUNT_EN
                    if (match) begin
                        count <= count + 1'b1;
                        if (!found) begin
                            found <= 1'b1;
                            vec   <= cand[IN_W-1:0];
                        end
                    end
                    if (!last) begin
                        cand <= cand + 1'b1;
                    end
`else
                    if (match) begin
                        found <= 1'b1;
                        vec   <= cand[IN_W-1:0];
                    end else if (!last) begin
                        cand <= cand + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // All outputs come straight from registers: no req->resp or
    // resp_ready->req_ready combinational path.
    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_found = found;
    assign bus.resp_vec   = vec;
    assign bus.cls_inp    = cand[IN_W-1:0];
`ifdef DTC_INV_COUNT_EN
    assign bus.resp_count = count;
`endif

endmodule

// File: tb/tb_dtc_class_inverter.sv
module tb_dtc_class_inverter;

    localparam int IN_W  = 12;
    localparam int OUT_W = 3;

    // Clock edges from the accepting edge to the edge that raises resp_valid.
`ifdef DTC_INV_COUNT_EN
    localparam int LAT_A00  = 4096;
    localparam int LAT_200  = 4096;
    localparam int LAT_E00  = 4096;
    localparam int LAT_ZERO = 4096;
`else
    localparam int LAT_A00  = 2561;
    localparam int LAT_200  = 513;
    localparam int LAT_E00  = 3585;
    localparam int LAT_ZERO = 1;
`endif
    localparam int LAT_NONE = 4096;

    logic clk;
    logic rst;
    int   mock_mode;
    int   checks;
    int   errors;

    dtc_class_inverter_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    dtc_class_inverter #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mock classifiers
    always_comb begin
        case (mock_mode)
            0:       bus.cls_outp = bus.cls_inp[11:9];
            1:       bus.cls_outp = {1'b0, bus.cls_inp[1:0]};
            default: bus.cls_outp = 3'b000;
        endcase
    end

    task automatic send_req(input logic [2:0] cls);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_class = cls;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_class = 3'b000;
    endtask

    // Called at the negedge after the accepting edge; counts edges until
    // resp_valid is seen or the budget runs out.
    task automatic wait_resp(input int budget, output int edges);
        edges = 0;
        while (bus.resp_valid !== 1'b1 && edges < budget) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic finish_resp();
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
        checks++; if (bus.resp_found !== 1'b0) begin errors++; $display("FAIL reset_resp_found: got %b expected 0", bus.resp_found); end
        checks++; if (bus.resp_vec !== 12'h000) begin errors++; $display("FAIL reset_resp_vec: got %h expected 000", bus.resp_vec); end
        checks++; if (bus.cls_inp !== 12'h000) begin errors++; $display("FAIL reset_cls_inp: got %h expected 000", bus.cls_inp); end
`ifdef DTC_INV_COUNT_EN
        checks++; if (bus.resp_count !== 13'd0) begin errors++; $display("FAIL reset_resp_count: got %0d expected 0", bus.resp_count); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_upper_bits();
        int e;
        mock_mode = 0;
        send_req(3'b101);
        wait_resp(LAT_A00 + 50, e);
        checks++; if (e != LAT_A00) begin errors++; $display("FAIL a00_latency: got %0d expected %0d", e, LAT_A00); end
        checks++; if (bus.resp_found !== 1'b1) begin errors++; $display("FAIL a00_found: got %b expected 1", bus.resp_found); end
        checks++; if (bus.resp_vec !== 12'hA00) begin errors++; $display("FAIL a00_vec: got %h expected a00", bus.resp_vec); end
`ifdef DTC_INV_COUNT_EN
        checks++; if (bus.resp_count !== 13'd512) begin errors++; $display("FAIL a00_count: got %0d expected 512", bus.resp_count); end
`endif
        finish_resp();
        checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL a00_return_idle: got ready=%b valid=%b expected ready=1 valid=0", bus.req_ready, bus.resp_valid); end
    endtask

    task automatic test_no_match();
        int e;
        mock_mode = 1;
        send_req(3'b100);
        wait_resp(LAT_NONE + 50, e);
        checks++; if (e != LAT_NONE) begin errors++; $display("FAIL nomatch_latency: got %0d expected %0d", e, LAT_NONE); end
        checks++; if (bus.resp_found !== 1'b0) begin errors++; $display("FAIL nomatch_found: got %b expected 0", bus.resp_found); end
        checks++; if (bus.resp_vec !== 12'h000) begin errors++; $display("FAIL nomatch_vec: got %h expected 000", bus.resp_vec); end
`ifdef DTC_INV_COUNT_EN
        checks++; if (bus.resp_count !== 13'd0) begin errors++; $display("FAIL nomatch_count: got %0d expected 0", bus.resp_count); end
`endif
        finish_resp();
    endtask

    task automatic test_const_zero();
        int e;
        mock_mode = 2;
        bus.resp_ready = 1'b1;
        send_req(3'b000);
        wait_resp(LAT_ZERO + 50, e);
        checks++; if (e != LAT_ZERO) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", e, LAT_ZERO); end
        checks++; if (bus.resp_found !== 1'b1) begin errors++; $display("FAIL zero_found: got %b expected 1", bus.resp_found); end
        checks++; if (bus.resp_vec !== 12'h000) begin errors++; $display("FAIL zero_vec: got %h expected 000", bus.resp_vec); end
`ifdef DTC_INV_COUNT_EN
        checks++; if (bus.resp_count !== 13'd4096) begin errors++; $display("FAIL zero_count: got %0d expected 4096", bus.resp_count); end
`endif
        // resp_ready held high: the response lasts exactly one cycle.
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL zero_one_cycle: got %b expected 0", bus.resp_valid); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL zero_ready_after: got %b expected 1", bus.req_ready); end
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int e;
        int bad;
        mock_mode = 0;
        send_req(3'b001);
        wait_resp(LAT_200 + 50, e);
        checks++; if (e != LAT_200) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", e, LAT_200); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            bus.req_valid = i[0];
            bus.req_class = 3'b111;
            @(posedge clk);
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.resp_found !== 1'b1 ||
                bus.resp_vec !== 12'h200 || bus.req_ready !== 1'b0) begin
                bad++;
            end
        end
        bus.req_valid = 1'b0;
        bus.req_class = 3'b000;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
        checks++; if (bus.resp_vec !== 12'h200) begin errors++; $display("FAIL bp_vec: got %h expected 200", bus.resp_vec); end
        finish_resp();
        // The ignored req_valid pulses must not have started a search.
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_after: got ready=%b valid=%b expected ready=1 valid=0", bus.req_ready, bus.resp_valid); end
    endtask

    task automatic test_reset_mid_search();
        int e;
        mock_mode = 0;
        send_req(3'b101);
        repeat (100) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.cls_inp !== 12'd100) begin errors++; $display("FAIL rstmid_cand: got %0d expected 100", bus.cls_inp); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_req_ready: got %b expected 1", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_resp_valid: got %b expected 0", bus.resp_valid); end
        checks++; if (bus.cls_inp !== 12'h000) begin errors++; $display("FAIL rstmid_cls_inp: got %h expected 000", bus.cls_inp); end
        @(negedge clk);
        rst = 1'b0;
        send_req(3'b101);
        wait_resp(LAT_A00 + 50, e);
        checks++; if (e != LAT_A00) begin errors++; $display("FAIL rstmid_latency: got %0d expected %0d", e, LAT_A00); end
        checks++; if (bus.resp_vec !== 12'hA00 || bus.resp_found !== 1'b1) begin errors++; $display("FAIL rstmid_vec: got %h found=%b expected a00 found=1", bus.resp_vec, bus.resp_found); end
        finish_resp();
    endtask

    task automatic test_back_to_back();
        int e;
        mock_mode = 0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_class = 3'b001;
        @(posedge clk);
        @(negedge clk);
        wait_resp(LAT_200 + 50, e);
        checks++; if (e != LAT_200) begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", e, LAT_200); end
        checks++; if (bus.resp_vec !== 12'h200) begin errors++; $display("FAIL b2b_first_vec: got %h expected 200", bus.resp_vec); end
        bus.req_class = 3'b111;
        // Response handshake edge: request still pending but not taken.
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got ready=%b valid=%b expected ready=1 valid=0", bus.req_ready, bus.resp_valid); end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_class = 3'b000;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got %b expected 0", bus.req_ready); end
        wait_resp(LAT_E00 + 50, e);
        checks++; if (e != LAT_E00) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", e, LAT_E00); end
        checks++; if (bus.resp_vec !== 12'hE00 || bus.resp_found !== 1'b1) begin errors++; $display("FAIL b2b_second_vec: got %h found=%b expected e00 found=1", bus.resp_vec, bus.resp_found); end
`ifdef DTC_INV_COUNT_EN
        checks++; if (bus.resp_count !== 13'd512) begin errors++; $display("FAIL b2b_second_count: got %0d expected 512", bus.resp_count); end
`endif
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_end_idle: got %b expected 1", bus.req_ready); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        mock_mode      = 0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_class  = 3'b000;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_upper_bits();
        test_no_match();
        test_const_zero();
        test_backpressure();
        test_reset_mid_search();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
